// File: rtl/data_ram_rsp.sv
// data_ram_rsp: responder end of the core's data-memory port.
// Word-organised single-port array, one-entry posted-write buffer with
// byte-lane merge, and an optional wait-state sequencer driving stallreq_o.
// Optional feature macro: DATA_RAM_RSP_FWD_EN
//   defined   -> reads forward matching lanes from the write buffer
//   undefined -> a read hitting the buffer stalls one cycle while it drains
module data_ram_rsp #(
    parameter int ADDR_WIDTH  = 17,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    // Number of S_WAIT cycles still to run, counting the current one.
    logic [3:0]              cnt_q, cnt_d;

    logic [31:0]             mem [DEPTH];

    logic                    wb_valid;
    logic [ADDR_WIDTH-1:0]   wb_idx;
    logic [31:0]             wb_data;
    logic [3:0]              wb_sel;

    logic [ADDR_WIDTH-1:0]   idx;
    logic                    wb_hit;
    logic                    rd_req;
    logic                    wr_req;
    logic                    hazard;
    logic                    stall_int;
    logic                    done;
    logic                    wr_accept;
    logic                    rd_done;
    logic                    drain;
    logic [31:0]             rd_word;
    logic [31:0]             rd_fwd;
    logic                    unused_addr;

    // Overwrite the lanes of base selected by sel with the lanes of upd.
    function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = upd[8*b +: 8];
        end
        return r;
    endfunction

    assign idx         = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
    assign wb_hit      = wb_valid && (wb_idx == idx);
    assign rd_req      = ce_i && !we_i;
    assign wr_req      = ce_i && we_i;

`ifdef DATA_RAM_RSP_FWD_EN
    assign hazard = 1'b0;
`else
    // Without forwarding a read of the buffered word must wait for the drain.
    assign hazard = rd_req && wb_hit;
`endif

    // Wait-state sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the presentation cycle is the first stall cycle, so the
    // sequencer spends WAIT_CYCLES-1 cycles in S_WAIT before S_DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ce_i && !hazard && (WAIT_CYCLES > 0)) begin
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs of the sequencer: stall request and access-completion strobe.
    always_comb begin
        stall_int = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    if (hazard || (WAIT_CYCLES > 0)) stall_int = 1'b1;
                    else                             done      = 1'b1;
                end
            end
            S_WAIT:  stall_int = 1'b1;
            S_DONE:  done      = ce_i;
            default: ;
        endcase
    end

    assign wr_accept = wr_req && done;
    assign rd_done   = rd_req && done;
    // The array port is free when idle, on a write to another word, or while
    // a read is stalled; a completing read owns the port.
    assign drain     = wb_valid && (!ce_i || (wr_accept && !wb_hit) || (rd_req && stall_int));

    // Buffer ownership flag; a pending write is discarded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
        end else if (wr_accept) begin
            wb_valid <= 1'b1;
        end else if (drain) begin
            wb_valid <= 1'b0;
        end
    end

    // Buffer payload: load a new word or merge lanes into the owned word.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            wb_idx <= idx;
            if (wb_hit) begin
                wb_data <= lane_merge(wb_data, data_i, sel_i);
                wb_sel  <= wb_sel | sel_i;
            end else begin
                wb_data <= data_i;
                wb_sel  <= sel_i;
            end
        end
    end

    // Drain the buffered lanes into the storage array.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel[b]) mem[wb_idx][8*b +: 8] <= wb_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

`ifdef DATA_RAM_RSP_FWD_EN
    assign rd_fwd = wb_hit ? lane_merge(rd_word, wb_data, wb_sel) : rd_word;
`else
    assign rd_fwd = rd_word;
`endif

    assign data_o     = (rst && rd_done) ? rd_fwd : 32'd0;
    assign stallreq_o = rst && stall_int;

endmodule
